uart_rx_os: RTL

Parametrised, oversampling UART receiver. Successor to the fixed 8N1, 27 MHz / 9600 baud receiver.
- Adds: configurable clock, baud, data width and oversampling; mid-bit majority-free centre sampling; false-start rejection; framing-error detection; valid/ready output handshake with overrun flag.
- Sits between the board RX pin and the CPU peripheral bus / RX FIFO.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_os_tick.sv | 36 +++
 rtl/uart_rx_os.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  // Clocks per oversampling tick, rounded to nearest, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int den;
    int q;
    den = baud * os;
    q   = (clk_freq + (den / 2)) / den;
    if (q < 1) begin
      return 1;
    end else begin
      return q;
    end
  endfunction

  // XOR reduction of a payload zero-extended to the widest frame.
  function automatic logic xor9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversampling tick generator: one-clk pulse every DIV clocks.
module uart_os_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count value: wrap to zero after DIV-1.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with valid/ready output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE) + 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] FULL_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  logic tick;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [SCW-1:0]       samp_q, samp_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 dlv_q, dlv_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state logic: synchroniser, frame FSM, and output handshake.
  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    dlv_d       = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          samp_d  = {SCW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (tick) begin
          if (samp_q == HALF_LAST) begin
            if (rx_s_q) begin
              // Start bit gone by its centre: treat as a glitch.
              state_d = IDLE;
            end else begin
              state_d = DATA;
              samp_d  = {SCW{1'b0}};
              bit_d   = {BCW{1'b0}};
            end
          end else begin
            samp_d = samp_q + SCW'(1);
          end
        end else begin
          samp_d = samp_q;
        end
      end

      DATA: begin
        if (tick) begin
          if (samp_q == FULL_LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            samp_d  = {SCW{1'b0}};
            if (bit_q == BIT_LAST) begin
              bit_d = {BCW{1'b0}};
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + BCW'(1);
            end
          end else begin
            samp_d = samp_q + SCW'(1);
          end
        end else begin
          samp_d = samp_q;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (samp_q == FULL_LAST) begin
            par_bad_d = rx_s_q ^ xor9(9'(shift_q)) ^ PARITY_ODD[0];
            samp_d    = {SCW{1'b0}};
            state_d   = STOP;
          end else begin
            samp_d = samp_q + SCW'(1);
          end
        end else begin
          samp_d = samp_q;
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (samp_q == FULL_LAST) begin
            samp_d = {SCW{1'b0}};
            if (rx_s_q) begin
              // Leave at mid-stop so an immediately following start bit is caught.
              dlv_d   = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            samp_d = samp_q + SCW'(1);
          end
        end else begin
          samp_d = samp_q;
        end
      end

      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Delivery one cycle after the mid-stop sample; the shift register is
    // still untouched because the FSM cannot reach DATA again this soon.
    if (dlv_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_q;
        out_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_bad_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      samp_q      <= {SCW{1'b0}};
      bit_q       <= {BCW{1'b0}};
      shift_q     <= {DATA_BITS{1'b0}};
      dlv_q       <= 1'b0;
      out_data_q  <= {DATA_BITS{1'b0}};
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      dlv_q       <= dlv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
